audio_pwm_out: RTL and testbench
================================

Name: audio_pwm_out

Overview:
- Downstream consumer of the sine generators' signed 8-bit amplitude stream.
- Accepts one sample per sample-rate strobe and holds it in a one-deep pending buffer.
- Applies volume attenuation and mute, then drives a single-bit PWM audio pin whose duty is updated only at PWM period boundaries.
- Flags underrun and overrun so the top level can detect rate mismatch between the tone path and the PWM period.

Parameters:
PWM_BITS, 8, width of PWM counter; period = 2**PWM_BITS clk_in cycles; must equal sample width.
VOL_BITS, 3, width of vol_in; attenuation = arithmetic right shift by vol_in (0..7).

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
sample_in  input  8  signed two's-complement sample (-128..127)
sample_valid_in  input  1  sample_in valid this cycle
sample_ready_out  output  1  pending buffer empty; sample accepted when valid & ready
vol_in  input  VOL_BITS  attenuation shift, sampled at period boundary
mute_in  input  1  force midscale duty, sampled at period boundary
pwm_out  output  1  PWM audio output, registered
underrun_out  output  1  one-cycle pulse: boundary reached with pending empty
overrun_out  output  1  one-cycle pulse: sample_valid_in high while sample_ready_out low (sample dropped)

Behaviour:
- Reset (rst_in low, async): cnt=0, pending_full=0, pending=0, duty_q=128 (midscale), last_sample=0, pwm_out=0, underrun_out=0, overrun_out=0. sample_ready_out is therefore 1 during and after reset.
- cnt: free-running PWM_BITS counter, 0..255, wraps 255->0. The boundary is the clock edge at which cnt==255.
- sample_ready_out = ~pending_full (combinational).
  - Accept: on an edge with valid & ready, pending<=sample_in and pending_full<=1.
  - Drop: valid & ~ready drops the sample, leaves pending unchanged, and pulses overrun_out the next cycle.
- Boundary edge, pending_full=1:
  - last_sample<=pending.
  - duty_q<=f(pending, vol_in, mute_in).
  - pending_full<=0.
- Boundary edge, pending_full=0:
  - duty_q<=f(last_sample, vol_in, mute_in), i.e. the last sample is repeated.
  - underrun_out pulses the next cycle.
- Duty function f(s, v, m):
  - m=1: 128.
  - Otherwise a = s >>> v (arithmetic, sign-preserving, 8-bit), duty = {~a[7], a[6:0]} (offset binary, 0..255).
- pwm_out <= (cnt < duty_q), registered, so one-cycle lag behind cnt.
  - High for exactly duty_q cycles of each 256-cycle period.
  - duty 0: constantly low. Duty 255: low 1 cycle per period.
- Latency: a sample accepted mid-period appears in pwm_out in the period after the next boundary, starting 1 cycle after that boundary.
- Simultaneous events:
  - Boundary with pending_full=1 and valid=1 on the same edge: ready is low, so the new sample is dropped and overrun pulses. Pending clears at that edge.
  - Boundary with pending_full=0 and valid=1: the sample is accepted into pending (not made active this period) and underrun pulses.
- vol_in/mute_in changes mid-period have no effect until the next boundary.
- Reset asserted mid-period: all state returns to reset values immediately. After release, cnt restarts at 0 and the first boundary is 256 edges later.

Decomposition:
- Package audio_pkg:
  - typedef logic signed [7:0] sample_t.
  - localparam PWM_MIDSCALE = 8'd128.
  - localparam PWM_PERIOD = 256.
- Sub-module sample_to_duty: combinational f(s, v, m), separately unit-testable. All state stays in audio_pwm_out.

Test Plan:
- Reset then idle, no samples → duty stays 128: pwm_out high 128 of 256 cycles each period; underrun_out pulses once per period, 1 cycle after each cnt==255 edge.
- sample_in=0x40, vol=0, mute=0, one valid mid-period → next full period pwm_out high exactly 192 cycles; no underrun in the loading period; underrun on later boundaries with repeat at 192.
- sample_in=-128 (0x80), vol=1 → a=-64, duty 64, 64 high cycles. Same sample with vol=7 → a=-1, duty 127.
- Two valids before one boundary (0x10 then 0x20) → second dropped, overrun_out 1-cycle pulse, ready low between them; the next period uses duty 144.
- mute_in=1 with sample 0x7F pending → duty 128 for that period; pending consumed, last_sample=0x7F. Release mute with no new sample → next period duty 255.
- rst_in low for 3 cycles at cnt=100 with pending_full=1 → pwm_out=0, ready=1, pending cleared. After release, the first boundary occurs at the 256th edge with underrun pulse and duty 128.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the PWM audio output path.
package audio_pkg;

  typedef logic signed [7:0] sample_t;

  localparam logic [7:0] PWM_MIDSCALE = 8'd128;
  localparam int         PWM_PERIOD   = 256;

endpackage

// File: rtl/audio_pwm_out_if.sv
// Sample stream from the tone path into the PWM output stage.
// Handshake: a sample transfers on a clock edge where sample_valid_in and
// sample_ready_out are both high; valid while ready is low means the sample
// is dropped (no back-pressure: the producer does not hold it).
interface audio_pwm_out_if;
  import audio_pkg::*;

  sample_t sample_in;
  logic    sample_valid_in;
  logic    sample_ready_out;

  modport master (
    output sample_in,
    output sample_valid_in,
    input  sample_ready_out
  );

  modport slave (
    input  sample_in,
    input  sample_valid_in,
    output sample_ready_out
  );
endinterface

// File: rtl/audio_pwm_out_sample_to_duty.sv
// Maps a signed sample to an offset-binary PWM duty with volume shift and mute.
module sample_to_duty
  import audio_pkg::*;
#(
  parameter int VOL_BITS = 3
) (
  input  sample_t             sample_in,
  input  logic [VOL_BITS-1:0] vol_in,
  input  logic                mute_in,
  output logic [7:0]          duty_out
);

  sample_t atten;

  // Arithmetic shift keeps the sign, then flip the MSB for offset binary.
  always_comb begin
    atten    = sample_in >>> vol_in;
    duty_out = mute_in ? PWM_MIDSCALE : {~atten[7], atten[6:0]};
  end

endmodule

// File: rtl/audio_pwm_out.sv
// PWM audio output stage: one-deep sample buffer, duty update at period
// boundaries, underrun/overrun pulses for rate-mismatch detection.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int PWM_BITS = $clog2(PWM_PERIOD),
  parameter int VOL_BITS = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  audio_pwm_out_if.slave      s_if,
  input  logic [VOL_BITS-1:0] vol_in,
  input  logic                mute_in,
  output logic                pwm_out,
  output logic                underrun_out,
  output logic                overrun_out
);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                pending_full_q, pending_full_d;
  sample_t             pending_q, pending_d;
  sample_t             last_sample_q, last_sample_d;
  logic [7:0]          duty_q, duty_d;
  logic                pwm_q, pwm_d;
  logic                underrun_q, underrun_d;
  logic                overrun_q, overrun_d;

  logic                boundary;
  logic                accept;
  sample_t             duty_src;
  logic [7:0]          next_duty;

  assign boundary              = (cnt_q == '1);
  assign s_if.sample_ready_out = ~pending_full_q;
  assign accept                = s_if.sample_valid_in & ~pending_full_q;

  // A fresh pending sample wins; otherwise the last one is repeated.
  assign duty_src = pending_full_q ? pending_q : last_sample_q;

  sample_to_duty #(
    .VOL_BITS (VOL_BITS)
  ) u_sample_to_duty (
    .sample_in (duty_src),
    .vol_in    (vol_in),
    .mute_in   (mute_in),
    .duty_out  (next_duty)
  );

  // Next-state: counter, buffer handshake, boundary duty load, status pulses.
  always_comb begin
    cnt_d          = cnt_q + 1'b1;
    pending_full_d = pending_full_q;
    pending_d      = pending_q;
    last_sample_d  = last_sample_q;
    duty_d         = duty_q;
    pwm_d          = (cnt_q < duty_q);
    underrun_d     = 1'b0;
    overrun_d      = s_if.sample_valid_in & pending_full_q;

    if (boundary) begin
      duty_d = next_duty;
      if (pending_full_q) begin
        last_sample_d  = pending_q;
        pending_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end

    // Accept only happens when the buffer was empty at this edge, so it never
    // collides with the boundary consuming the buffer.
    if (accept) begin
      pending_d      = s_if.sample_in;
      pending_full_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q          <= '0;
      pending_full_q <= 1'b0;
      pending_q      <= '0;
      last_sample_q  <= '0;
      duty_q         <= PWM_MIDSCALE;
      pwm_q          <= 1'b0;
      underrun_q     <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pending_full_q <= pending_full_d;
      pending_q      <= pending_d;
      last_sample_q  <= last_sample_d;
      duty_q         <= duty_d;
      pwm_q          <= pwm_d;
      underrun_q     <= underrun_d;
      overrun_q      <= overrun_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign underrun_out = underrun_q;
  assign overrun_out  = overrun_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out: reset, idle duty, sample load latency,
// volume, overrun, mute, and mid-period reset.
module tb_audio_pwm_out;
  import audio_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [2:0] vol_in = 3'd0;
  logic       mute_in = 1'b0;
  logic       pwm_out;
  logic       underrun_out;
  logic       overrun_out;

  always #5 clk_in = ~clk_in;

  audio_pwm_out_if sif ();

  audio_pwm_out dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .s_if         (sif),
    .vol_in       (vol_in),
    .mute_in      (mute_in),
    .pwm_out      (pwm_out),
    .underrun_out (underrun_out),
    .overrun_out  (overrun_out)
  );

  int n_pass  = 0;
  int n_total = 0;
  int edge_n  = 0;   // edges since reset release; cnt == edge_n % 256

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
    edge_n++;
  endtask

  task automatic drive_sample(input logic [7:0] s);
    sif.sample_in       = s;
    sif.sample_valid_in = 1'b1;
    tick();
    sif.sample_valid_in = 1'b0;
  endtask

  // Advance until the boundary edge has just happened.
  task automatic run_to_boundary(output int und);
    und = 0;
    do begin
      tick();
      if (underrun_out) und++;
    end while (edge_n % PWM_PERIOD != 0);
  endtask

  // Observe one full PWM period starting right after a boundary edge.
  task automatic measure(output int hi, output int und, output int und_pos, output int ovr);
    hi = 0; und = 0; und_pos = 0; ovr = 0;
    for (int i = 1; i <= PWM_PERIOD; i++) begin
      tick();
      if (pwm_out) hi++;
      if (underrun_out) begin und++; und_pos = i; end
      if (overrun_out) ovr++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) tick();
    n_total++;
    if (pwm_out !== 1'b0) $display("FAIL reset_pwm: got %b want 0", pwm_out); else n_pass++;
    n_total++;
    if (sif.sample_ready_out !== 1'b1) $display("FAIL reset_ready: got %b want 1", sif.sample_ready_out); else n_pass++;
    n_total++;
    if (underrun_out !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun_out); else n_pass++;
    n_total++;
    if (overrun_out !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun_out); else n_pass++;
    rst_in = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_idle();
    int hi, und, up, ovr;
    for (int p = 0; p < 2; p++) begin
      measure(hi, und, up, ovr);
      n_total++;
      if (hi !== 128) $display("FAIL idle_high p%0d: got %0d want 128", p, hi); else n_pass++;
      n_total++;
      if (und !== 1 || up !== 256) $display("FAIL idle_underrun p%0d: got count %0d at %0d want 1 at 256", p, und, up); else n_pass++;
    end
  endtask

  task automatic test_single_sample();
    int hi, und, up, ovr;
    repeat (100) tick();
    n_total++;
    if (sif.sample_ready_out !== 1'b1) $display("FAIL load_ready_before: got %b want 1", sif.sample_ready_out); else n_pass++;
    drive_sample(8'h40);
    n_total++;
    if (sif.sample_ready_out !== 1'b0) $display("FAIL load_ready_after: got %b want 0", sif.sample_ready_out); else n_pass++;
    run_to_boundary(und);
    n_total++;
    if (und !== 0) $display("FAIL load_no_underrun: got %0d want 0", und); else n_pass++;
    n_total++;
    if (sif.sample_ready_out !== 1'b1) $display("FAIL load_ready_consumed: got %b want 1", sif.sample_ready_out); else n_pass++;
    measure(hi, und, up, ovr);
    n_total++;
    if (hi !== 192) $display("FAIL load_high: got %0d want 192", hi); else n_pass++;
    n_total++;
    if (und !== 1 || up !== 256) $display("FAIL load_repeat_underrun: got count %0d at %0d want 1 at 256", und, up); else n_pass++;
    measure(hi, und, up, ovr);
    n_total++;
    if (hi !== 192) $display("FAIL load_repeat_high: got %0d want 192", hi); else n_pass++;
  endtask

  task automatic test_volume();
    int hi, und, up, ovr;
    repeat (50) tick();
    drive_sample(8'h80);
    vol_in = 3'd1;
    run_to_boundary(und);
    measure(hi, und, up, ovr);
    n_total++;
    if (hi !== 64) $display("FAIL vol1_high: got %0d want 64", hi); else n_pass++;
    repeat (50) tick();
    drive_sample(8'h80);
    vol_in = 3'd7;
    run_to_boundary(und);
    vol_in = 3'd0;   // mid-period change must not affect this period
    measure(hi, und, up, ovr);
    n_total++;
    if (hi !== 127) $display("FAIL vol7_high: got %0d want 127", hi); else n_pass++;
  endtask

  task automatic test_overrun();
    int hi, und, up, ovr;
    repeat (60) tick();
    drive_sample(8'h10);
    n_total++;
    if (sif.sample_ready_out !== 1'b0) $display("FAIL ovr_ready_low: got %b want 0", sif.sample_ready_out); else n_pass++;
    n_total++;
    if (overrun_out !== 1'b0) $display("FAIL ovr_none_on_accept: got %b want 0", overrun_out); else n_pass++;
    drive_sample(8'h20);
    n_total++;
    if (overrun_out !== 1'b1) $display("FAIL ovr_pulse: got %b want 1", overrun_out); else n_pass++;
    tick();
    n_total++;
    if (overrun_out !== 1'b0) $display("FAIL ovr_pulse_width: got %b want 0", overrun_out); else n_pass++;
    run_to_boundary(und);
    measure(hi, und, up, ovr);
    n_total++;
    if (hi !== 144) $display("FAIL ovr_kept_first: got %0d want 144", hi); else n_pass++;
  endtask

  task automatic test_mute();
    int hi, und, up, ovr;
    repeat (70) tick();
    drive_sample(8'h7f);
    mute_in = 1'b1;
    run_to_boundary(und);
    mute_in = 1'b0;  // takes effect only at the next boundary
    measure(hi, und, up, ovr);
    n_total++;
    if (hi !== 128) $display("FAIL mute_high: got %0d want 128", hi); else n_pass++;
    n_total++;
    if (und !== 1 || up !== 256) $display("FAIL mute_underrun: got count %0d at %0d want 1 at 256", und, up); else n_pass++;
    measure(hi, und, up, ovr);
    n_total++;
    if (hi !== 255) $display("FAIL unmute_repeat_high: got %0d want 255", hi); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int hi, und, up, ovr;
    repeat (99) tick();
    drive_sample(8'h40);
    n_total++;
    if (pwm_out !== 1'b1 || sif.sample_ready_out !== 1'b0)
      $display("FAIL rstmid_pre: got pwm %b ready %b want 1 0", pwm_out, sif.sample_ready_out);
    else n_pass++;
    rst_in = 1'b0;
    #1;
    n_total++;
    if (pwm_out !== 1'b0 || sif.sample_ready_out !== 1'b1)
      $display("FAIL rstmid_async: got pwm %b ready %b want 0 1", pwm_out, sif.sample_ready_out);
    else n_pass++;
    repeat (3) tick();
    n_total++;
    if (pwm_out !== 1'b0 || sif.sample_ready_out !== 1'b1)
      $display("FAIL rstmid_hold: got pwm %b ready %b want 0 1", pwm_out, sif.sample_ready_out);
    else n_pass++;
    rst_in = 1'b1;
    edge_n = 0;
    measure(hi, und, up, ovr);
    n_total++;
    if (hi !== 128) $display("FAIL rstmid_high: got %0d want 128", hi); else n_pass++;
    n_total++;
    if (und !== 1 || up !== 256) $display("FAIL rstmid_underrun: got count %0d at %0d want 1 at 256", und, up); else n_pass++;
    measure(hi, und, up, ovr);
    n_total++;
    if (hi !== 128) $display("FAIL rstmid_pending_cleared: got %0d want 128", hi); else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    sif.sample_in       = '0;
    sif.sample_valid_in = 1'b0;
    test_reset();
    test_idle();
    test_single_sample();
    test_volume();
    test_overrun();
    test_mute();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
